prbs_share_arbiter: RTL and testbench

//  Shares one PRBS31 generator (x^31 + x^28 + 1) between two requesters.

---
 rtl/prbs_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_prbs_share_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_share_arbiter.sv
// prbs_share_arbiter: shares one PRBS31 generator (x^31 + x^28 + 1) between two
// requesters under round-robin arbitration. Each grant streams BURST_BYTES bytes
// over a valid/ready handshake. The LFSR runs continuously across bursts.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active-high (historical name)
//   req[1:0]    level requests, bit 0 = requester 0
//   gnt[1:0]    one-hot grant, held for the whole burst
//   byte_out    PRBS byte, first generated bit in bit 7
//   byte_valid  byte_out valid
//   byte_ready  consumer accepts byte_out
//   burst_done  one-cycle pulse after the last byte handshake
//   busy        high in any state other than IDLE
//   seed_load   load seed_in into the LFSR (IDLE only)
//   seed_in     new LFSR state (zero is replaced by 1)
//   err_inject  (PRBS_ERR_INJ_EN only) arms a one-shot bit-0 flip of the next byte
//
// Build option: define PRBS_ERR_INJ_EN to add the err_inject port and logic.
module prbs_share_arbiter #(
    parameter int unsigned BURST_BYTES = 4,
    parameter logic [30:0] SEED        = 31'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        burst_done,
    output logic        busy,
    input  logic        seed_load,
    input  logic [30:0] seed_in
`ifdef PRBS_ERR_INJ_EN
    ,
    input  logic        err_inject
`endif
);

    localparam int unsigned LFSR_W = 31;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BURST_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_HOLD,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [BYTE_W-2:0]   shreg_q;
    logic [2:0]          bit_cnt_q;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic                rr_q;        // index of the last-served requester
    logic [1:0]          gnt_q;
    logic [BYTE_W-1:0]   byte_out_q;
    logic                byte_valid_q;
    logic                burst_done_q;
    logic                busy_q;
`ifdef PRBS_ERR_INJ_EN
    logic                err_flag_q;
`endif

    logic                out_bit;
    logic [LFSR_W-1:0]   lfsr_step;
    logic [BYTE_W-1:0]   shreg_nxt;
    logic [BYTE_W-1:0]   byte_load;
    logic [1:0]          gnt_pick;

    // LFSR step and MSB-first byte assembly
    assign out_bit   = lfsr_q[30];
    assign lfsr_step = {lfsr_q[29:0], lfsr_q[27] ^ lfsr_q[30]};
    assign shreg_nxt = {shreg_q, out_bit};
`ifdef PRBS_ERR_INJ_EN
    assign byte_load = shreg_nxt ^ {7'd0, err_flag_q};
`else
    assign byte_load = shreg_nxt;
`endif

    // Round-robin pick: the last-served requester gets the lower priority
    always_comb begin
        gnt_pick = 2'b00;
        if (rr_q) begin
            if (req[0])      gnt_pick = 2'b01;
            else if (req[1]) gnt_pick = 2'b10;
        end else begin
            if (req[1])      gnt_pick = 2'b10;
            else if (req[0]) gnt_pick = 2'b01;
        end
    end

    // Arbitration / generation FSM with registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            rr_q         <= 1'b1;
            gnt_q        <= 2'b00;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            burst_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PRBS_ERR_INJ_EN
            err_flag_q   <= 1'b0;
`endif
        end else begin
            burst_done_q <= 1'b0;
`ifdef PRBS_ERR_INJ_EN
            err_flag_q   <= err_flag_q | err_inject;
`endif
            case (state_q)
                S_IDLE: begin
                    if (seed_load) begin
                        lfsr_q <= (seed_in == '0) ? LFSR_W'(1) : seed_in;
                    end else if (req != 2'b00) begin
                        gnt_q      <= gnt_pick;
                        busy_q     <= 1'b1;
                        byte_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        state_q    <= S_GEN;
                    end
                end
                S_GEN: begin
                    lfsr_q    <= lfsr_step;
                    shreg_q   <= shreg_nxt[BYTE_W-2:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_out_q   <= byte_load;
                        byte_valid_q <= 1'b1;
                        state_q      <= S_HOLD;
`ifdef PRBS_ERR_INJ_EN
                        // flag is consumed by this byte; a concurrent pulse re-arms it
                        err_flag_q   <= err_inject;
`endif
                    end
                end
                S_HOLD: begin
                    if (byte_ready) begin
                        byte_valid_q <= 1'b0;
                        byte_cnt_q   <= byte_cnt_q + CNT_W'(1);
                        if (byte_cnt_q == LAST_BYTE) begin
                            burst_done_q <= 1'b1;
                            gnt_q        <= 2'b00;
                            rr_q         <= gnt_q[1];
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_GEN;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt        = gnt_q;
    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign burst_done = burst_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_prbs_share_arbiter.sv
// tb_prbs_share_arbiter: directed self-checking bench for prbs_share_arbiter
// (BURST_BYTES=4, SEED=1). Define PRBS_ERR_INJ_EN to also exercise err_inject.
module tb_prbs_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        burst_done;
    logic        busy;
    logic        seed_load;
    logic [30:0] seed_in;
`ifdef PRBS_ERR_INJ_EN
    logic        err_inject;
`endif

    int n_total = 0;
    int n_pass  = 0;

    // First 32 PRBS bits from seed 1: only step 31 outputs a one
    logic [7:0]  first_burst [4] = '{8'h00, 8'h00, 8'h00, 8'h02};
    logic [30:0] m_lfsr;

    prbs_share_arbiter #(.BURST_BYTES(4), .SEED(31'd1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .burst_done (burst_done),
        .busy       (busy),
        .seed_load  (seed_load),
        .seed_in    (seed_in)
`ifdef PRBS_ERR_INJ_EN
        ,
        .err_inject (err_inject)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference PRBS31 byte from the polynomial, MSB first
    task automatic model_byte(output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b      = {b[6:0], m_lfsr[30]};
            m_lfsr = {m_lfsr[29:0], m_lfsr[27] ^ m_lfsr[30]};
        end
    endtask

    // Wait (bounded) for byte_valid, optionally stall, then let the handshake happen
    task automatic get_byte(input int stall, output logic [7:0] b, output int waited);
        waited = 0;
        while (!byte_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("byte_valid", 32'(byte_valid), 32'd1);
        b = byte_out;
        if (stall > 0) begin
            byte_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                check("stall_valid", 32'(byte_valid), 32'd1);
                check("stall_byte", 32'(byte_out), 32'(b));
            end
            byte_ready = 1'b1;
        end
        @(negedge clk);
        check("valid_drop", 32'(byte_valid), 32'd0);
    endtask

    logic [7:0] b;
    logic [7:0] exp_b;
    logic [1:0] exp_g;
    int         w;

    initial begin
        rst_n      = 1'b1;
        req        = 2'b00;
        byte_ready = 1'b1;
        seed_load  = 1'b0;
        seed_in    = '0;
`ifdef PRBS_ERR_INJ_EN
        err_inject = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // 1: reset state, then a single burst from requester 0
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(burst_done), 32'd0);
        check("rst_byte", 32'(byte_out), 32'd0);
        rst_n = 1'b0;
        req   = 2'b01;
        @(negedge clk);
        check("s1_gnt", 32'(gnt), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            get_byte(0, b, w);
            check("s1_byte", 32'(b), 32'(first_burst[i]));
            check("s1_latency", 32'(w), 32'd8);
        end
        check("s1_done", 32'(burst_done), 32'd1);
        check("s1_done_gnt", 32'(gnt), 32'd0);
        check("s1_done_busy", 32'(busy), 32'd1);
        req = 2'b00;
        @(negedge clk);
        check("s1_idle_done", 32'(burst_done), 32'd0);
        check("s1_idle_busy", 32'(busy), 32'd0);

        // 2: both requesting from reset alternates 01,10,01 with a two-cycle gap
        rst_n = 1'b1;
        @(negedge clk);
        rst_n  = 1'b0;
        req    = 2'b11;
        m_lfsr = 31'd1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_g = (k == 1) ? 2'b10 : 2'b01;
            check("s2_gnt", 32'(gnt), 32'(exp_g));
            for (int i = 0; i < 4; i++) begin
                get_byte(0, b, w);
                model_byte(exp_b);
                check("s2_byte", 32'(b), 32'(exp_b));
                if (i < 3) check("s2_gnt_hold", 32'(gnt), 32'(exp_g));
            end
            check("s2_done", 32'(burst_done), 32'd1);
            if (k == 2) req = 2'b01;
            @(negedge clk);
            check("s2_gap", 32'(gnt), 32'd0);
            @(negedge clk);
        end

        // 3: consumer stalls five cycles on the second byte; sequence continues
        check("s3_gnt", 32'(gnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            get_byte((i == 1) ? 5 : 0, b, w);
            model_byte(exp_b);
            check("s3_byte", 32'(b), 32'(exp_b));
        end
        check("s3_done", 32'(burst_done), 32'd1);
        req = 2'b00;
        @(negedge clk);

        // 4: zero seed load beats req; seed_load and req drop mid-burst are ignored
        seed_load = 1'b1;
        seed_in   = 31'd0;
        req       = 2'b01;
        @(negedge clk);
        check("s4_no_gnt", 32'(gnt), 32'd0);
        check("s4_no_busy", 32'(busy), 32'd0);
        seed_load = 1'b0;
        @(negedge clk);
        check("s4_gnt", 32'(gnt), 32'd1);
        req       = 2'b00;
        seed_load = 1'b1;
        seed_in   = 31'h5a5a5a5;
        @(negedge clk);
        seed_load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            get_byte(0, b, w);
            check("s4_byte", 32'(b), 32'(first_burst[i]));
            if (i < 3) check("s4_gnt_hold", 32'(gnt), 32'd1);
        end
        check("s4_done", 32'(burst_done), 32'd1);
        @(negedge clk);

        // 5: reset in the middle of the second byte, then restart from SEED
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        get_byte(0, b, w);
        check("s5_byte0", 32'(b), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("s5_rst_gnt", 32'(gnt), 32'd0);
        check("s5_rst_busy", 32'(busy), 32'd0);
        check("s5_rst_valid", 32'(byte_valid), 32'd0);
        check("s5_rst_done", 32'(burst_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 2'b01;
        @(negedge clk);
        check("s5_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            get_byte(0, b, w);
            check("s5_byte", 32'(b), 32'(first_burst[i]));
        end
        check("s5_done", 32'(burst_done), 32'd1);
        @(negedge clk);

`ifdef PRBS_ERR_INJ_EN
        // 6: err_inject pulse in IDLE flips bit 0 of the first byte only
        rst_n = 1'b1;
        @(negedge clk);
        rst_n      = 1'b0;
        err_inject = 1'b1;
        @(negedge clk);
        err_inject = 1'b0;
        req        = 2'b01;
        @(negedge clk);
        check("s6_gnt", 32'(gnt), 32'd1);
        req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            get_byte(0, b, w);
            check("s6_byte", 32'(b), 32'(first_burst[i] ^ ((i == 0) ? 8'h01 : 8'h00)));
        end
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
